// File: rtl/ex_operand_stage.sv
// Decode->execute operand stage: head register plus one skid register feeding the ALUSrc operand mux.
// Latency 1 cycle from accept to out_valid when the head is free or being emitted in the same cycle.
// Backpressure: in_ready is registered (count<2 after the edge), so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   flush              synchronous discard of every held entry (wins over accept and emit)
//   in_valid/in_ready  decode handshake; in_* carry register indices, read data, immediate and control
//   out_valid/out_ready EX handshake; out_* present the head entry (operand A, mux in0/in1/sel, rd, regwrite)
module ex_operand_stage #(
    parameter int          DATA_W   = 64,
    parameter logic [4:0]  ZERO_REG = 5'd31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rn_addr,
    input  logic [4:0]        in_rm_addr,
    input  logic [DATA_W-1:0] in_rn_data,
    input  logic [DATA_W-1:0] in_rm_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_alusrc,
    input  logic [4:0]        in_rd_addr,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b_reg,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_alusrc,
    output logic [4:0]        out_rd_addr,
    output logic              out_regwrite
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic              alusrc;
        logic [4:0]        rd;
        logic              regwrite;
    } entry_t;

    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     in_entry;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;
    logic       emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = (count_q != 2'd0) & out_ready;

    // The zero register is resolved at capture so EX never sees stale regfile data for it.
    always_comb begin
        in_entry.a        = (in_rn_addr == ZERO_REG) ? '0 : in_rn_data;
        in_entry.b        = (in_rm_addr == ZERO_REG) ? '0 : in_rm_data;
        in_entry.imm      = in_imm;
        in_entry.alusrc   = in_alusrc;
        in_entry.rd       = in_rd_addr;
        in_entry.regwrite = in_regwrite;
    end

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    head_d  = in_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({accept, emit})
                    2'b11: head_d = in_entry;          // head leaves, new entry replaces it
                    2'b01: count_d = 2'd0;
                    2'b10: begin                       // head stalled: park in skid
                        skid_d  = in_entry;
                        count_d = 2'd2;
                    end
                    default: ;
                endcase
            end
            2'd2: begin
                // in_ready_q is low here, so only an emit can change state.
                if (emit) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
        // Data registers may still load during a flush; they are unobservable with out_valid low.
        if (flush) begin
            count_d = 2'd0;
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_a        = head_q.a;
    assign out_b_reg    = head_q.b;
    assign out_imm      = head_q.imm;
    assign out_alusrc   = head_q.alusrc;
    assign out_rd_addr  = head_q.rd;
    assign out_regwrite = head_q.regwrite;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus pushes expected entries on accept,
// a negedge monitor pops and compares on every emit and checks stall stability.
// Directed cases for latency, skid fill, zero register, flush and async reset, then random traffic.
module tb_ex_operand_stage;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic        alusrc;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rn_addr;
    logic [4:0]  in_rm_addr;
    logic [63:0] in_rn_data;
    logic [63:0] in_rm_data;
    logic [63:0] in_imm;
    logic        in_alusrc;
    logic [4:0]  in_rd_addr;
    logic        in_regwrite;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a;
    logic [63:0] out_b_reg;
    logic [63:0] out_imm;
    logic        out_alusrc;
    logic [4:0]  out_rd_addr;
    logic        out_regwrite;

    int   checks;
    int   errors;
    exp_t sb[$];

    ex_operand_stage #(.DATA_W(64), .ZERO_REG(5'd31)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rn_addr   (in_rn_addr),
        .in_rm_addr   (in_rm_addr),
        .in_rn_data   (in_rn_data),
        .in_rm_data   (in_rm_data),
        .in_imm       (in_imm),
        .in_alusrc    (in_alusrc),
        .in_rd_addr   (in_rd_addr),
        .in_regwrite  (in_regwrite),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b_reg    (out_b_reg),
        .out_imm      (out_imm),
        .out_alusrc   (out_alusrc),
        .out_rd_addr  (out_rd_addr),
        .out_regwrite (out_regwrite)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rn, input logic [63:0] rnd, input logic [4:0] rm,
                          input logic [63:0] rmd, input logic [63:0] imm, input logic als,
                          input logic [4:0] rd, input logic rw);
        in_rn_addr  = rn;
        in_rn_data  = rnd;
        in_rm_addr  = rm;
        in_rm_data  = rmd;
        in_imm      = imm;
        in_alusrc   = als;
        in_rd_addr  = rd;
        in_regwrite = rw;
    endtask

    // Holds in_valid until the stage takes the entry; expected a/b are supplied by the caller.
    task automatic send(input logic [4:0] rn, input logic [63:0] rnd, input logic [4:0] rm,
                        input logic [63:0] rmd, input logic [63:0] imm, input logic als,
                        input logic [4:0] rd, input logic rw, input logic [63:0] ea,
                        input logic [63:0] eb, input bit rnd_rdy);
        exp_t e;
        e = '{a: ea, b: eb, imm: imm, alusrc: als, rd: rd, rw: rw};
        set_in(rn, rnd, rm, rmd, imm, als, rd, rw);
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                step();
                in_valid = 1'b0;
                if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
                return;
            end
            step();
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready never rose, required within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic send_tag(input logic [63:0] tag);
        send(5'd3, tag, 5'd4, tag + 64'h10, tag + 64'h20, 1'b0, tag[4:0], 1'b1,
             tag, tag + 64'h10, 1'b0);
    endtask

    // Monitor: compares every emitted head against the scoreboard and checks that a
    // stalled head does not change or drop before it is taken.
    initial begin
        exp_t snap;
        exp_t cur;
        exp_t e;
        bit   prev_stall;
        prev_stall = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            cur = '{a: out_a, b: out_b_reg, imm: out_imm, alusrc: out_alusrc,
                    rd: out_rd_addr, rw: out_regwrite};
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 200'(out_valid), 200'd1);
                    chk("stall_data", 200'(cur), 200'(snap));
                end
                if (!flush && out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_emit: got entry %0h, required no output", cur);
                    end else begin
                        e = sb.pop_front();
                        chk("emit_a", 200'(out_a), 200'(e.a));
                        chk("emit_b_reg", 200'(out_b_reg), 200'(e.b));
                        chk("emit_imm", 200'(out_imm), 200'(e.imm));
                        chk("emit_ctrl", 200'({out_alusrc, out_rd_addr, out_regwrite}),
                            200'({e.alusrc, e.rd, e.rw}));
                    end
                end
                prev_stall = out_valid && !out_ready && !flush;
                snap = cur;
            end
        end
    end

    initial begin
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [63:0] rnd;
        logic [63:0] rmd;
        logic [63:0] imm;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in('0, '0, '0, '0, '0, 1'b0, '0, 1'b0);

        // Reset state
        #2;
        chk("rst_out_valid", 200'(out_valid), 200'd0);
        chk("rst_in_ready", 200'(in_ready), 200'd0);
        chk("rst_data", 200'({out_a, out_b_reg, out_imm}), 200'd0);
        chk("rst_ctrl", 200'({out_alusrc, out_rd_addr, out_regwrite}), 200'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        chk("rst_release_in_ready", 200'(in_ready), 200'd1);

        // 1: basic capture, latency 1
        out_ready = 1'b1;
        send(5'd1, 64'h5, 5'd2, 64'h7, 64'h10, 1'b1, 5'd9, 1'b1, 64'h5, 64'h7, 1'b0);
        chk("t1_latency_valid", 200'(out_valid), 200'd1);
        chk("t1_alusrc", 200'(out_alusrc), 200'd1);
        step();
        chk("t1_idle_valid", 200'(out_valid), 200'd0);

        // 2: fill head + skid, third held, then drain in order
        out_ready = 1'b0;
        send_tag(64'hA);
        send_tag(64'hB);
        chk("t2_full_in_ready", 200'(in_ready), 200'd0);
        set_in(5'd3, 64'hC, 5'd4, 64'h1C, 64'h2C, 1'b0, 5'hC, 1'b1);
        in_valid = 1'b1;
        step();
        step();
        chk("t2_held_in_ready", 200'(in_ready), 200'd0);
        chk("t2_head_still_a", 200'(out_a), 200'hA);
        out_ready = 1'b1;
        send_tag(64'hC);
        repeat (3) step();
        chk("t2_drained", 200'(sb.size()), 200'd0);

        // 3: zero register on both sources, then only on A
        send(5'd31, 64'hDEAD, 5'd31, 64'hBEEF, 64'h1234, 1'b1, 5'd7, 1'b1, 64'h0, 64'h0, 1'b0);
        send(5'd31, 64'hDEAD, 5'd5, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5'd8, 1'b0,
             64'h0, 64'hBEEF, 1'b0);
        send(5'd6, 64'h1111, 5'd31, 64'h2222, 64'h3, 1'b0, 5'd31, 1'b1, 64'h1111, 64'h0, 1'b0);
        repeat (2) step();

        // 4: flush with count=2 and a concurrent incoming entry
        out_ready = 1'b0;
        send_tag(64'h40);
        send_tag(64'h41);
        chk("t4_count2_in_ready", 200'(in_ready), 200'd0);
        set_in(5'd3, 64'h42, 5'd4, 64'h52, 64'h62, 1'b0, 5'd2, 1'b1);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("t4_flush_valid", 200'(out_valid), 200'd0);
        chk("t4_flush_in_ready", 200'(in_ready), 200'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // 5: asynchronous reset mid-cycle with a stalled entry
        out_ready = 1'b0;
        send_tag(64'h77);
        chk("t5_pre_valid", 200'(out_valid), 200'd1);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        chk("t5_async_valid", 200'(out_valid), 200'd0);
        chk("t5_async_in_ready", 200'(in_ready), 200'd0);
        chk("t5_async_data", 200'({out_a, out_b_reg, out_imm}), 200'd0);
        chk("t5_async_ctrl", 200'({out_alusrc, out_rd_addr, out_regwrite}), 200'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("t5_release_in_ready", 200'(in_ready), 200'd1);
        chk("t5_release_valid", 200'(out_valid), 200'd0);
        out_ready = 1'b1;
        send_tag(64'h88);
        chk("t5_latency_valid", 200'(out_valid), 200'd1);
        step();

        // 6: random valid/ready traffic
        out_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            rm  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            rnd = {$urandom, $urandom};
            rmd = {$urandom, $urandom};
            imm = {$urandom, $urandom};
            send(rn, rnd, rm, rmd, imm, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), (rn == 5'd31) ? 64'h0 : rnd,
                 (rm == 5'd31) ? 64'h0 : rmd, 1'b1);
            repeat ($urandom_range(0, 1)) begin
                step();
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = 1'b1;
        repeat (5) step();
        chk("t6_drained", 200'(sb.size()), 200'd0);
        chk("t6_idle_valid", 200'(out_valid), 200'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
